// File: rtl/proc_control_fsm.sv
// Multi-cycle control FSM for the 8-register processor: latches IR in T0, walks T1..T3, decodes strobes.
// Optional PROC_CTRL_PERF_EN adds a 16-bit retired-instruction counter port (instr_count).
module proc_control_fsm #(
    parameter int SEL_W = 3,
    parameter int OPC_W = 3,
    localparam int IR_W = OPC_W + 2 * SEL_W
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Run,
    input  logic [IR_W-1:0]  DIN,
    output logic [SEL_W-1:0] rout_sel,
    output logic             rout_en,
    output logic [SEL_W-1:0] rin_sel,
    output logic             rin_en,
    output logic             DINout,
    output logic             Ain,
    output logic             Gin,
    output logic             Gout,
    output logic             AddSub,
`ifdef PROC_CTRL_PERF_EN
    output logic             Done,
    output logic [15:0]      instr_count
`else
    output logic             Done
`endif
);

    typedef enum logic [1:0] {T0, T1, T2, T3} state_t;

    localparam logic [OPC_W-1:0] OP_MV  = OPC_W'(0);
    localparam logic [OPC_W-1:0] OP_MVI = OPC_W'(1);
    localparam logic [OPC_W-1:0] OP_ADD = OPC_W'(2);
    localparam logic [OPC_W-1:0] OP_SUB = OPC_W'(3);

    state_t            state_q, state_d;
    logic [IR_W-1:0]   ir_q, ir_d;
    logic [OPC_W-1:0]  opc;
    logic [SEL_W-1:0]  rx, ry;
    logic              is_alu;

    assign opc    = ir_q[IR_W-1 -: OPC_W];
    assign rx     = ir_q[2*SEL_W-1 -: SEL_W];
    assign ry     = ir_q[SEL_W-1:0];
    assign is_alu = (opc == OP_ADD) || (opc == OP_SUB);

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q <= T0;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        ir_d     = ir_q;
        rout_sel = '0;
        rout_en  = 1'b0;
        rin_sel  = '0;
        rin_en   = 1'b0;
        DINout   = 1'b0;
        Ain      = 1'b0;
        Gin      = 1'b0;
        Gout     = 1'b0;
        AddSub   = 1'b0;
        Done     = 1'b0;
        case (state_q)
            T0: begin
                // Run/DIN are only looked at here, so mid-instruction changes are harmless
                if (Run) begin
                    ir_d    = DIN;
                    state_d = T1;
                end
            end
            T1: begin
                case (opc)
                    OP_MV: begin
                        rout_sel = ry;
                        rout_en  = 1'b1;
                        rin_sel  = rx;
                        rin_en   = 1'b1;
                        Done     = 1'b1;
                    end
                    OP_MVI: begin
                        DINout  = 1'b1;
                        rin_sel = rx;
                        rin_en  = 1'b1;
                        Done    = 1'b1;
                    end
                    OP_ADD, OP_SUB: begin
                        rout_sel = rx;
                        rout_en  = 1'b1;
                        Ain      = 1'b1;
                        state_d  = T2;
                    end
                    default: Done = 1'b1;
                endcase
            end
            T2: begin
                if (is_alu) begin
                    rout_sel = ry;
                    rout_en  = 1'b1;
                    Gin      = 1'b1;
                    AddSub   = (opc == OP_SUB);
                    state_d  = T3;
                end else begin
                    state_d = T0;
                end
            end
            T3: begin
                if (is_alu) begin
                    Gout    = 1'b1;
                    rin_sel = rx;
                    rin_en  = 1'b1;
                    Done    = 1'b1;
                end else begin
                    state_d = T0;
                end
            end
            default: state_d = T0;
        endcase
        if (Done)
            state_d = T0;
    end

`ifdef PROC_CTRL_PERF_EN
    logic [15:0] instr_count_q, instr_count_d;

    always_comb begin
        instr_count_d = instr_count_q + {15'd0, Done};
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset)
            instr_count_q <= '0;
        else
            instr_count_q <= instr_count_d;
    end

    assign instr_count = instr_count_q;
`endif

endmodule

// File: tb/tb_proc_control_fsm.sv
// Directed bench for proc_control_fsm: hand-computed strobe vectors per time slot.
module tb_proc_control_fsm;

    logic       Clock, Reset, Run;
    logic [8:0] DIN;
    logic [2:0] rout_sel, rin_sel;
    logic       rout_en, rin_en, DINout, Ain, Gin, Gout, AddSub, Done;
`ifdef PROC_CTRL_PERF_EN
    logic [15:0] instr_count;
`endif

    int tests = 0;
    int fails = 0;

    proc_control_fsm dut (
        .Clock(Clock), .Reset(Reset), .Run(Run), .DIN(DIN),
        .rout_sel(rout_sel), .rout_en(rout_en), .rin_sel(rin_sel), .rin_en(rin_en),
        .DINout(DINout), .Ain(Ain), .Gin(Gin), .Gout(Gout), .AddSub(AddSub),
`ifdef PROC_CTRL_PERF_EN
        .Done(Done), .instr_count(instr_count)
`else
        .Done(Done)
`endif
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // {rout_en, rout_sel, rin_en, rin_sel, DINout, Ain, Gin, Gout, AddSub, Done}
    logic [13:0] obs;
    assign obs = {rout_en, rout_sel, rin_en, rin_sel, DINout, Ain, Gin, Gout, AddSub, Done};

    function automatic logic [13:0] ev(input logic re, input logic [2:0] rs,
                                       input logic we, input logic [2:0] ws,
                                       input logic dinout, input logic ain, input logic gin,
                                       input logic gout, input logic addsub, input logic done);
        return {re, rs, we, ws, dinout, ain, gin, gout, addsub, done};
    endfunction

    task automatic chk(input string tag, input logic [15:0] o, input logic [15:0] e);
        tests++;
        assert (o === e) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, o, e);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    localparam logic [13:0] IDLE = 14'd0;

    initial begin
        Reset = 1'b1;
        Run   = 1'b0;
        DIN   = 9'd0;
        #3;
        chk("reset_outputs", {2'b0, obs}, {2'b0, IDLE});
        tick();
        Reset = 1'b0;
        tick();
        chk("idle_t0", {2'b0, obs}, {2'b0, IDLE});

        // mv R2,R5 with a one-cycle Run pulse
        Run = 1'b1; DIN = 9'b000_010_101;
        chk("mv_t0", {2'b0, obs}, {2'b0, IDLE});
        tick(); Run = 1'b0;
        chk("mv_t1", {2'b0, obs}, {2'b0, ev(1, 3'd5, 1, 3'd2, 0, 0, 0, 0, 0, 1)});
        tick();
        chk("mv_after", {2'b0, obs}, {2'b0, IDLE});

        // mvi R7
        Run = 1'b1; DIN = 9'b001_111_000;
        tick(); Run = 1'b0;
        chk("mvi_t1", {2'b0, obs}, {2'b0, ev(0, 3'd0, 1, 3'd7, 1, 0, 0, 0, 0, 1)});
        tick();
        chk("mvi_after", {2'b0, obs}, {2'b0, IDLE});

        // sub R1,R3
        Run = 1'b1; DIN = 9'b011_001_011;
        tick(); Run = 1'b0;
        chk("sub_t1", {2'b0, obs}, {2'b0, ev(1, 3'd1, 0, 3'd0, 0, 1, 0, 0, 0, 0)});
        tick();
        chk("sub_t2", {2'b0, obs}, {2'b0, ev(1, 3'd3, 0, 3'd0, 0, 0, 1, 0, 1, 0)});
        tick();
        chk("sub_t3", {2'b0, obs}, {2'b0, ev(0, 3'd0, 1, 3'd1, 0, 0, 0, 1, 0, 1)});
        tick();
        chk("sub_after", {2'b0, obs}, {2'b0, IDLE});

        // reserved opcode: Done only in T1
        Run = 1'b1; DIN = 9'b111_101_110;
        tick(); Run = 1'b0;
        chk("nop_t1", {2'b0, obs}, {2'b0, ev(0, 3'd0, 0, 3'd0, 0, 0, 0, 0, 0, 1)});
        tick();
        chk("nop_after", {2'b0, obs}, {2'b0, IDLE});

        // add R1,R2 aborted by Reset in T2
        Run = 1'b1; DIN = 9'b010_001_010;
        tick(); Run = 1'b0;
        chk("abort_t1", {2'b0, obs}, {2'b0, ev(1, 3'd1, 0, 3'd0, 0, 1, 0, 0, 0, 0)});
        tick();
        chk("abort_t2", {2'b0, obs}, {2'b0, ev(1, 3'd2, 0, 3'd0, 0, 0, 1, 0, 0, 0)});
        Reset = 1'b1;
        #1;
        chk("abort_in_reset", {2'b0, obs}, {2'b0, IDLE});
        tick();
        chk("abort_reset_held", {2'b0, obs}, {2'b0, IDLE});
        Reset = 1'b0;
        tick();
        chk("abort_release", {2'b0, obs}, {2'b0, IDLE});
        tick();
        chk("abort_no_done", {2'b0, obs}, {2'b0, IDLE});

        // back-to-back: add R0,R4 then mv R6,R0 with Run held and DIN toggled mid-instruction
        Run = 1'b1; DIN = 9'b010_000_100;
        tick(); DIN = 9'h1FF;
        chk("b2b_add_t1", {2'b0, obs}, {2'b0, ev(1, 3'd0, 0, 3'd0, 0, 1, 0, 0, 0, 0)});
        tick();
        chk("b2b_add_t2", {2'b0, obs}, {2'b0, ev(1, 3'd4, 0, 3'd0, 0, 0, 1, 0, 0, 0)});
        tick();
        chk("b2b_add_t3", {2'b0, obs}, {2'b0, ev(0, 3'd0, 1, 3'd0, 0, 0, 0, 1, 0, 1)});
        tick(); DIN = 9'b000_110_000;
        chk("b2b_t0", {2'b0, obs}, {2'b0, IDLE});
        tick(); Run = 1'b0;
        chk("b2b_mv_t1", {2'b0, obs}, {2'b0, ev(1, 3'd0, 1, 3'd6, 0, 0, 0, 0, 0, 1)});
        tick();
        chk("b2b_after", {2'b0, obs}, {2'b0, IDLE});

`ifdef PROC_CTRL_PERF_EN
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        chk("cnt_reset", instr_count, 16'd0);
        Run = 1'b1; DIN = 9'b000_001_010;
        tick(); tick();
        DIN = 9'b111_000_000;
        tick(); tick();
        DIN = 9'b010_011_100;
        tick(); Run = 1'b0;
        tick(); tick(); tick();
        chk("cnt_three", instr_count, 16'd3);
        force dut.instr_count_q = 16'hFFFF;
        #1;
        release dut.instr_count_q;
        Run = 1'b1; DIN = 9'b000_001_010;
        tick(); Run = 1'b0;
        tick();
        chk("cnt_wrap", instr_count, 16'h0000);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
